paralelo_serial: RTL
====================

# paralelo_serial

Transmit-side counterpart of the PHY serial-to-parallel receiver. Takes one 9-bit word per slot (bit 8 = valid, bits 7:0 = data) and serializes it onto a 2-bit lane at the 16f clock, four clocks per byte, MSB pair first. After reset it sends a training burst of comma words (8'hBC) so the far-end receiver can reach its active state. Afterwards it sends the comma whenever no valid data is offered. It sits between the mux stage and the physical lane.

## Interface

Parameters:
- COMMA, 8'hBC, idle/training symbol; never transmitted as data.
- TRAIN_WORDS, 4, number of comma slots sent after reset or retrain before the first data slot; legal range 1..7.

Ports:
- clk16  input  1  16f lane clock; all state changes on its rising edge.
- reset16  input  1  asynchronous, active-low reset.
- inParalelo  input  9  [8] valid, [7:0] data; sampled only on edges where ready=1.
- ready  output  1  sample strobe; high during phase 3 of a slot in which inParalelo will be captured at the next edge.
- serial  output  2  lane output pair.
- comma_err  output  1  one-cycle pulse, registered; a valid word equal to COMMA was offered and dropped.
- retrain  input  1  only present with PARALELOSERIAL_RETRAIN_EN.

## Operation

- Registers:
  - phase: 2-bit, free-running 0→1→2→3→0.
  - word: 8-bit current slot word.
  - state: TRAIN/ACTIVE.
  - train_cnt: 3-bit.
- Lane mapping:
  - serial is a pure combinational function of the registers word and phase; there is no path from input to output.
  - phase 0 drives word[7:6], phase 1 drives word[5:4], phase 2 drives word[3:2], phase 3 drives word[1:0].
- Reset (asynchronous, while reset16=0):
  - phase=0, state=TRAIN, train_cnt=0, word=COMMA, comma_err=0.
  - As a result, serial=2'b10 and ready=0 during reset.
- TRAIN state:
  - At each edge with phase=3, train_cnt increments and word reloads COMMA.
  - In the last training slot (train_cnt==TRAIN_WORDS-1), ready=1 during phase 3. At that edge, state moves to ACTIVE and word loads from inParalelo using the ACTIVE rules.
- ACTIVE state:
  - ready=1 during every phase 3.
  - At each phase-3 edge, the next word is chosen as follows:
    - inParalelo[8]=1 and data≠COMMA: word←data.
    - inParalelo[8]=1 and data==COMMA: word←COMMA, and comma_err=1 for the following cycle.
    - inParalelo[8]=0: word←COMMA (idle fill).
- ready is combinational: (phase==3) && (state==ACTIVE || train_cnt==TRAIN_WORDS-1) && !retrain.
- Reset mid-slot: the partial word is abandoned immediately and training restarts from slot 0.

## Timing

- Cycle 0 is the cycle in which reset16 rises. The first edge after release moves phase from 0 to 1.
- Slot n occupies cycles 4n..4n+3.
- Slots 0..TRAIN_WORDS-1 carry COMMA.
- First ready: cycle 4·TRAIN_WORDS-1 (cycle 15 for the default).
- Latency: a word sampled at the end of slot n appears entirely in slot n+1. Bits 7:6 appear in the cycle directly after the sampling edge; bits 1:0 appear three cycles later.
- comma_err asserts in the cycle after the sampling edge and lasts exactly one cycle.
- Throughput: one byte per 4 clocks; no back-pressure beyond the ready strobe.
- inParalelo is don't-care in every cycle where ready=0.

## Configuration

- PARALELOSERIAL_RETRAIN_EN defined:
  - Adds the retrain input.
  - If retrain=1 at a phase-3 edge: state←TRAIN, train_cnt←0, word←COMMA, and inParalelo is ignored (ready is held 0 in that cycle).
  - retrain at any other phase has no effect.
  - retrain asserted during TRAIN restarts the count.
- Not defined: no retrain port; training occurs only after reset.

## Structure

- Shared package phy_pkg holds:
  - COMMA_SYM = 8'hBC, shared with the receiver.
  - PHASE_W = 2 and the slot length of 4.
  - The tx_state_t enum {TRAIN, ACTIVE}.
- No sub-module is warranted; the phase counter, FSM and lane mux stay in one module of roughly 150 lines.

## Test plan

1. Reset release with inParalelo=9'h1A5 held:
   - serial shows 10,11,11,00 repeated for 4 slots (cycles 0–15).
   - ready first rises at cycle 15.
   - Slot 4 shows 10,10,01,01 (0xA5).
2. Back-to-back data 0x12, 0x34, 0xFF with valid=1 on consecutive ready strobes → lane pairs 00,01,00,10 / 00,11,01,00 / 11,11,11,11 with no gaps.
3. valid=0 at a strobe → that slot carries 0xBC; comma_err stays 0.
4. valid=1 with data=0xBC at a strobe → slot carries 0xBC, and comma_err pulses high for exactly one cycle after the edge.
5. reset16 pulled low during phase 2 of a data slot → serial goes to 2'b10 and ready to 0 immediately. After release, a full 4-comma training burst is sent.
6. Loopback into the serial-to-parallel receiver with 20 random valid words:
   - The receiver's outParalelo[7:0] matches every word in order, with outParalelo[8]=1.
   - With PARALELOSERIAL_RETRAIN_EN, a retrain pulse at a phase-3 edge yields exactly 4 commas before data resumes.

Source files
------------

// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : phy_pkg
//  Description : Definitions shared by the PHY serializer and deserializer.
//                Holds the comma symbol, the slot geometry (four 2-bit
//                pairs per byte) and the transmitter state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package phy_pkg;

    // Idle / training symbol. Never carried as payload.
    localparam logic [7:0] COMMA_SYM = 8'hBC;

    // Lane slot geometry: one byte is sent as four 2-bit pairs.
    localparam int PHASE_W  = 2;
    localparam int SLOT_LEN = 4;

    // Transmitter state.
    typedef enum logic [0:0] {
        TRAIN  = 1'b0,
        ACTIVE = 1'b1
    } tx_state_t;

endpackage : phy_pkg
`default_nettype wire

// File: rtl/paralelo_serial.sv
`default_nettype none
// ============================================================================
//  Module      : paralelo_serial
//  Description : Byte-to-lane serializer. Accepts one 9-bit word per 4-clock
//                slot ({valid, data}) and drives it onto a 2-bit lane, MSB
//                pair first. After reset a burst of TRAIN_WORDS comma slots
//                is sent so the far-end receiver can lock; afterwards the
//                comma fills every slot without valid data.
//
//  Ports       : clk16       - lane clock, all state changes on rising edge
//                reset16     - asynchronous, active-low reset
//                inParalelo  - [8] valid, [7:0] data; captured when ready=1
//                retrain     - restart training at a slot boundary
//                              (only with PARALELOSERIAL_RETRAIN_EN)
//                ready       - high in phase 3 of a slot whose next word is
//                              taken from inParalelo at the coming edge
//                serial      - 2-bit lane output
//                comma_err   - one-cycle pulse: a valid comma was offered
//                              as data and dropped
//
//  Options     : PARALELOSERIAL_RETRAIN_EN - adds the retrain input.
//  Revision    : 1.0 - initial release
// ============================================================================
module paralelo_serial
    import phy_pkg::*;
#(
    parameter logic [7:0] COMMA       = COMMA_SYM,
    parameter int         TRAIN_WORDS = 4
) (
    input  logic       clk16,
    input  logic       reset16,
    input  logic [8:0] inParalelo,
`ifdef PARALELOSERIAL_RETRAIN_EN
    input  logic       retrain,
`endif
    output logic       ready,
    output logic [1:0] serial,
    output logic       comma_err
);

    localparam logic [2:0]         c_last_train = 3'(TRAIN_WORDS - 1);
    localparam logic [PHASE_W-1:0] c_last_phase = PHASE_W'(SLOT_LEN - 1);

    logic [PHASE_W-1:0] phase_q,     phase_d;
    logic [7:0]         word_q,      word_d;
    tx_state_t          state_q,     state_d;
    logic [2:0]         train_cnt_q, train_cnt_d;
    logic               comma_err_q, comma_err_d;

    logic w_retrain;
    logic w_slot_end;
    logic w_last_train;

`ifdef PARALELOSERIAL_RETRAIN_EN
    assign w_retrain = retrain;
`else
    assign w_retrain = 1'b0;
`endif

    assign w_slot_end   = (phase_q == c_last_phase);
    assign w_last_train = (train_cnt_q == c_last_train);

    // The last training slot already samples input so data follows the
    // burst with no idle gap; a retrain request masks the strobe.
    assign ready = w_slot_end && ((state_q == ACTIVE) || w_last_train) && !w_retrain;

    assign comma_err = comma_err_q;

    // Next-state logic. Everything except the phase counter only moves at
    // the slot boundary (phase 3 edge).
    always_comb begin
        phase_d     = phase_q + 1'b1;
        word_d      = word_q;
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        comma_err_d = 1'b0;

        if (w_slot_end) begin
            if (w_retrain) begin
                state_d     = TRAIN;
                train_cnt_d = '0;
                word_d      = COMMA;
            end else if (ready) begin
                state_d = ACTIVE;
                if (inParalelo[8] && (inParalelo[7:0] != COMMA)) begin
                    word_d = inParalelo[7:0];
                end else begin
                    // Idle fill, or a valid comma that cannot be sent as data.
                    word_d      = COMMA;
                    comma_err_d = inParalelo[8];
                end
            end else begin
                train_cnt_d = train_cnt_q + 1'b1;
                word_d      = COMMA;
            end
        end
    end

    // Lane mux: purely from registers, so no input-to-output path exists.
    always_comb begin
        serial = word_q[7:6];
        case (phase_q)
            2'd0:    serial = word_q[7:6];
            2'd1:    serial = word_q[5:4];
            2'd2:    serial = word_q[3:2];
            default: serial = word_q[1:0];
        endcase
    end

    always_ff @(posedge clk16 or negedge reset16) begin
        if (!reset16) begin
            phase_q     <= '0;
            word_q      <= COMMA;
            state_q     <= TRAIN;
            train_cnt_q <= '0;
            comma_err_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            word_q      <= word_d;
            state_q     <= state_d;
            train_cnt_q <= train_cnt_d;
            comma_err_q <= comma_err_d;
        end
    end

endmodule : paralelo_serial
`default_nettype wire
